id_issue_ctrl: RTL
==================

# id_issue_ctrl

Parametrised decode-stage issue controller for the 5-stage LoongArch pipeline. It holds the instruction/PC register between IF and EX and runs the valid/allowin handshake on both sides. It forwards operands from a configurable number of downstream stages and stalls on not-yet-ready results. It adds a long-latency scoreboard (loads to a blocking cache, divides) that the original fixed three-stage ID hazard logic lacks, together with flush support.

## Interface
- NUM_FWD, 3, number of downstream forwarding sources; index 0 is nearest (EX), NUM_FWD-1 farthest (WB)
- XLEN, 32, data width
- ADDR_W, 32, PC width
- MAX_LONG, 4, maximum outstanding long-latency ops (power of two not required, ≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  IF has an instruction
- in_allowin  out  1  ID can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  ADDR_W  instruction PC
- flush  in  1  kill held instruction (branch taken / exception)
- held_inst  out  32  currently held instruction, drives external decoder
- held_pc  out  ADDR_W  currently held PC
- rs1_addr, rs2_addr  in  5 each  source register numbers from decoder
- need_rs1, need_rs2  in  1 each  source actually read
- dst_addr  in  5  destination register; 0 means no write
- dst_long  in  1  held instruction is long-latency
- rf_rdata1, rf_rdata2  in  XLEN each  register file read data
- fwd_we  in  NUM_FWD  stage holds valid writing instruction
- fwd_pending  in  NUM_FWD  that stage's result not yet available
- fwd_waddr  in  5*NUM_FWD  packed destination numbers
- fwd_wdata  in  XLEN*NUM_FWD  packed result data
- lat_done  in  1  a long-latency op wrote back this cycle
- lat_done_addr  in  5  its destination
- out_valid  out  1  issue to EX
- out_allowin  in  1  EX can accept
- rs1_value, rs2_value  out  XLEN each  forwarded operands
- stall_cause  out  2  0 none, 1 pending-forward, 2 scoreboard source/WAW, 3 scoreboard full

## Operation
- Held register: ds_valid, held_inst, held_pc. It loads when in_valid & in_allowin. Otherwise ds_valid clears when the held instruction issues (out_valid & out_allowin).
- in_allowin = ~ds_valid | (ready_go & out_allowin). out_valid = ds_valid & ready_go & ~flush.
- Forwarding per source: scan stages 0..NUM_FWD-1 and take the first with fwd_we[i] & waddr==src & src!=0. Nearest wins. No match selects rf_rdata. r0 always reads rf value (0).
- Pending stall: the matched nearest stage has fwd_pending set and need_rsX → stall_cause 1. A farther non-pending match does not override it.
- Scoreboard: busy[31:1] bit vector plus count (0..MAX_LONG).
  - Issue of an instruction with dst_long & dst_addr≠0 sets busy[dst] and increments count.
  - lat_done clears busy[lat_done_addr] and decrements count.
  - Same-cycle set and clear: on the same register, set wins; count is unchanged.
- Scoreboard stall (cause 2): a needed source is busy and not cleared this cycle, or the destination is busy (WAW).
- Full stall (cause 3): dst_long & count==MAX_LONG & ~lat_done.
- Priority of stall_cause: 1 > 2 > 3. ready_go = (cause==0). stall_cause reports 0 when ~ds_valid.
- Flush: ds_valid clears next cycle, and out_valid is 0 in the flush cycle. If in_valid is high in the same cycle, flush wins and nothing is loaded. The scoreboard is not altered by flush; issued ops still complete.
- lat_done with the busy bit already clear is ignored: no count underflow, count saturates at 0.

## Timing
- Reset: ds_valid=0, held_inst=0, held_pc=0, busy=0, count=0. Consequently in_allowin=1, out_valid=0, stall_cause=0.
- ID occupies one cycle when not stalled. An instruction loaded at edge N issues at edge N+1.
- Forward and stall paths are combinational from fwd_*, lat_done and decoder inputs within the cycle. Scoreboard updates are visible the next cycle, except for the same-cycle lat_done bypass.
- Back-pressure: out_allowin=0 holds the instruction and PC stable, and in_allowin=0.
- Reset asserted mid-stall or with outstanding ops clears everything next edge. Late lat_done pulses after reset are ignored per the rule above.

## Test plan
- Back-to-back add r3 then add r4,r3,r3 with EX fwd_we[0]=1, waddr=3, wdata=0x1234 → rs1_value=rs2_value=0x1234, no stall, issues in 1 cycle.
- Load r5 in EX (fwd_pending[0]=1) followed by a consumer of r5 → stall_cause=1 for 1 cycle. Next cycle MEM match with value 0xDEAD is forwarded and the instruction issues.
- Stages 0 and 2 both write r7 (0xAAAA, 0xBBBB) → 0xAAAA is selected. Source r0 with fwd_waddr=0 → rf value.
- Issue div to r8 (dst_long), then a consumer of r8 → stall_cause=2 until lat_done with addr 8. A consumer presented in the lat_done cycle issues that same cycle.
- MAX_LONG=4: issue 4 long ops to r1..r4, then a 5th long op → stall_cause=3. One lat_done → it issues and count returns to 4.
- Flush while stalled on cause 2 with in_valid=1 → out_valid=0, ds_valid=0 next cycle, busy bits unchanged. Reset mid-stream → all outputs return to reset values.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: holds the IF->ID instruction register and forwards operands.
// It also tracks long-latency destinations in a scoreboard and stalls issue until operands are ready.
module id_issue_ctrl #(
  parameter int NUM_FWD  = 3,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_LONG = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // IF side
  input  logic                    in_valid,
  output logic                    in_allowin,
  input  logic [31:0]             in_inst,
  input  logic [ADDR_W-1:0]       in_pc,
  input  logic                    flush,
  output logic [31:0]             held_inst,
  output logic [ADDR_W-1:0]       held_pc,
  // decoder view of the held instruction
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic                    need_rs1,
  input  logic                    need_rs2,
  input  logic [4:0]              dst_addr,
  input  logic                    dst_long,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  // downstream forwarding sources
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata,
  // long-latency completion
  input  logic                    lat_done,
  input  logic [4:0]              lat_done_addr,
  // EX side
  output logic                    out_valid,
  input  logic                    out_allowin,
  output logic [XLEN-1:0]         rs1_value,
  output logic [XLEN-1:0]         rs2_value,
  output logic [1:0]              stall_cause
);

  localparam int CNT_W = $clog2(MAX_LONG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LONG);

  typedef struct packed {
    logic            hit;
    logic            pend;
    logic [XLEN-1:0] data;
  } fwd_t;

  // Nearest stage wins, so scan from farthest to nearest and let later hits override.
  function automatic fwd_t fwd_pick(
    input logic [4:0]              src,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      we,
    input logic [NUM_FWD-1:0]      pend,
    input logic [5*NUM_FWD-1:0]    waddr,
    input logic [XLEN*NUM_FWD-1:0] wdata
  );
    fwd_t r;
    r.hit  = 1'b0;
    r.pend = 1'b0;
    r.data = rf;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && (src != 5'd0) && (waddr[i*5 +: 5] == src)) begin
        r.hit  = 1'b1;
        r.pend = pend[i];
        r.data = wdata[i*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  logic              ds_valid_q, ds_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;

  fwd_t fwd1, fwd2;
  logic pend_stall, sb_stall, full_stall;
  logic src1_busy, src2_busy, waw;
  logic ready_go, issue, load, set_en, clr_en;

  // ---- operand forwarding ----
  always_comb begin
    fwd1 = fwd_pick(rs1_addr, rf_rdata1, fwd_we, fwd_pending, fwd_waddr, fwd_wdata);
    fwd2 = fwd_pick(rs2_addr, rf_rdata2, fwd_we, fwd_pending, fwd_waddr, fwd_wdata);
  end

  assign rs1_value = fwd1.data;
  assign rs2_value = fwd2.data;

  // ---- hazard detection ----
  always_comb begin
    pend_stall = (need_rs1 && fwd1.hit && fwd1.pend) ||
                 (need_rs2 && fwd2.hit && fwd2.pend);
    // a completion in this cycle releases a waiting source immediately
    src1_busy  = need_rs1 && (rs1_addr != 5'd0) && busy_q[rs1_addr] &&
                 !(lat_done && (lat_done_addr == rs1_addr));
    src2_busy  = need_rs2 && (rs2_addr != 5'd0) && busy_q[rs2_addr] &&
                 !(lat_done && (lat_done_addr == rs2_addr));
    waw        = (dst_addr != 5'd0) && busy_q[dst_addr];
    sb_stall   = src1_busy || src2_busy || waw;
    full_stall = dst_long && (count_q == CNT_MAX) && !lat_done;

    stall_cause = 2'd0;
    if (ds_valid_q) begin
      if (pend_stall)      stall_cause = 2'd1;
      else if (sb_stall)   stall_cause = 2'd2;
      else if (full_stall) stall_cause = 2'd3;
    end
  end

  assign ready_go   = (stall_cause == 2'd0);
  assign in_allowin = !ds_valid_q || (ready_go && out_allowin);
  assign out_valid  = ds_valid_q && ready_go && !flush;
  assign issue      = out_valid && out_allowin;
  assign load       = in_valid && in_allowin && !flush;
  assign held_inst  = inst_q;
  assign held_pc    = pc_q;

  // ---- held register next state ----
  always_comb begin
    ds_valid_d = ds_valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (load) begin
      ds_valid_d = 1'b1;
      inst_d     = in_inst;
      pc_d       = in_pc;
    end else if (issue) begin
      ds_valid_d = 1'b0;
    end
  end

  // ---- scoreboard next state ----
  always_comb begin
    set_en  = issue && dst_long && (dst_addr != 5'd0);
    // completions for registers not marked busy are stale and ignored
    clr_en  = lat_done && (lat_done_addr != 5'd0) && busy_q[lat_done_addr];
    busy_d  = busy_q;
    count_d = count_q;
    if (clr_en) busy_d[lat_done_addr] = 1'b0;
    if (set_en) busy_d[dst_addr]      = 1'b1;
    if (set_en && !clr_en && (count_q != CNT_MAX))
      count_d = count_q + 1'b1;
    else if (!set_en && clr_en && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      busy_q     <= '0;
      count_q    <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

endmodule
